spram_bhw: RTL and testbench

SPRAM_BHW -- requirements
Module: spram_bhw

---
 rtl/spram_bhw.sv | 238 +++++++++++++++++++++++
 tb/tb_spram_bhw.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/spram_bhw.sv
// rtl/spram_bhw.sv - byte-addressable wrapper over cascaded 32K x 32 SPRAM banks
// Unaligned accesses that cross a word boundary are split into two beats.
module spram_bhw #(
    parameter int BANKS = 4,
    parameter int AW    = 15 + $clog2(BANKS) + 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic          we,
    input  logic [1:0]    sz,
    input  logic          sx,
    input  logic [AW-1:0] ai,
    input  logic [31:0]   vi,
    output logic [31:0]   vo,
    output logic          ack,
    output logic          busy
);
    localparam int WW = AW - 2;
    localparam int BW = (BANKS > 1) ? $clog2(BANKS) : 1;
    localparam logic [WW:0] DEPTH = (WW+1)'(BANKS * 32768);
    localparam logic [BW:0] NBANK = (BW+1)'(BANKS);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SPLIT = 1'b1;

    logic [WW-1:0] w_in;
    logic [1:0]    o_in;
    logic [2:0]    n_in;
    logic          split_in;
    logic [7:0]    mask_in;
    logic [63:0]   data_in;

    assign w_in = ai[AW-1:2];
    assign o_in = ai[1:0];

    always_comb begin
        case (sz)
            2'd0:    n_in = 3'd1;
            2'd1:    n_in = 3'd2;
            default: n_in = 3'd4;
        endcase
    end

    // Lanes [3:0] belong to word w, lanes [7:4] spill into word w+1.
    assign split_in = ({1'b0, o_in} + n_in) > 3'd4;
    assign mask_in  = ((8'd1 << n_in) - 8'd1) << o_in;
    assign data_in  = {32'd0, vi} << {o_in, 3'b000};

    logic [0:0]    state_q, state_d;
    logic [WW-1:0] w_q;
    logic [1:0]    o_q;
    logic [1:0]    sz_q;
    logic          sx_q;
    logic          we_q;
    logic [3:0]    mask_hi_q;
    logic [31:0]   data_hi_q;

    logic [WW:0]   wp1;
    logic [WW-1:0] w_nxt;

    assign wp1   = {1'b0, w_q} + (WW+1)'(1);
    assign w_nxt = (wp1 >= DEPTH) ? '0 : wp1[WW-1:0];

    logic          beat_en;
    logic          beat_we;
    logic [WW-1:0] beat_w;
    logic [3:0]    beat_mask;
    logic [31:0]   beat_data;
    logic [1:0]    iss_o;
    logic [1:0]    iss_sz;
    logic          iss_sx;
    logic          iss_ack;
    logic          iss_b1;

    always_comb begin
        state_d   = state_q;
        beat_en   = 1'b0;
        beat_we   = we;
        beat_w    = w_in;
        beat_mask = mask_in[3:0];
        beat_data = data_in[31:0];
        iss_o     = o_in;
        iss_sz    = sz;
        iss_sx    = sx;
        iss_ack   = 1'b0;
        iss_b1    = 1'b0;
        if (!rst) begin
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        beat_en = 1'b1;
                        iss_ack = !split_in;
                        iss_b1  = split_in && !we;
                        if (split_in) begin
                            state_d = S_SPLIT;
                        end
                    end
                end
                default: begin
                    beat_en   = 1'b1;
                    beat_we   = we_q;
                    beat_w    = w_nxt;
                    beat_mask = mask_hi_q;
                    beat_data = data_hi_q;
                    iss_o     = o_q;
                    iss_sz    = sz_q;
                    iss_sx    = sx_q;
                    iss_ack   = 1'b1;
                    state_d   = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            w_q       <= '0;
            o_q       <= '0;
            sz_q      <= '0;
            sx_q      <= 1'b0;
            we_q      <= 1'b0;
            mask_hi_q <= '0;
            data_hi_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && req && split_in) begin
                w_q       <= w_in;
                o_q       <= o_in;
                sz_q      <= sz;
                sx_q      <= sx;
                we_q      <= we;
                mask_hi_q <= mask_in[7:4];
                data_hi_q <= data_in[63:32];
            end
        end
    end

    logic [BW-1:0] bsel;
    logic [14:0]   row;

    assign row = beat_w[14:0];

    generate
        if (BANKS > 1) begin : g_bsel
            assign bsel = beat_w[WW-1:15];
        end else begin : g_bsel1
            assign bsel = '0;
        end
    endgenerate

    logic [BANKS-1:0][31:0] bank_rd;

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        logic [31:0] mem [32768];
        logic [31:0] rd_q;

        always_ff @(posedge clk) begin
            if (beat_en && bsel == BW'(b)) begin
                if (beat_we) begin
                    for (int i = 0; i < 4; i++) begin
                        if (beat_mask[i]) begin
                            mem[row][8*i +: 8] <= beat_data[8*i +: 8];
                        end
                    end
                end else begin
                    rd_q <= mem[row];
                end
            end
        end

        assign bank_rd[b] = rd_q;
    end

    // Tags travel with the read data so the merge sees the issuing cycle's view.
    logic          p_ack_q;
    logic          p_rd_q;
    logic          p_b1_q;
    logic          p_split_q;
    logic [1:0]    p_o_q;
    logic [1:0]    p_sz_q;
    logic          p_sx_q;
    logic [BW-1:0] rsel_q;
    logic [31:0]   hold_q;
    logic [31:0]   rdata;

    assign rdata = ({1'b0, rsel_q} < NBANK) ? bank_rd[rsel_q] : 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            p_ack_q   <= 1'b0;
            p_rd_q    <= 1'b0;
            p_b1_q    <= 1'b0;
            p_split_q <= 1'b0;
            p_o_q     <= '0;
            p_sz_q    <= '0;
            p_sx_q    <= 1'b0;
            rsel_q    <= '0;
            hold_q    <= '0;
        end else begin
            p_ack_q   <= iss_ack;
            p_rd_q    <= beat_en && !beat_we;
            p_b1_q    <= iss_b1;
            p_split_q <= beat_en && state_q == S_SPLIT;
            if (beat_en) begin
                p_o_q  <= iss_o;
                p_sz_q <= iss_sz;
                p_sx_q <= iss_sx;
            end
            if (beat_en && !beat_we) begin
                rsel_q <= bsel;
            end
            if (p_b1_q) begin
                hold_q <= rdata;
            end
        end
    end

    logic [63:0] pair;
    logic [31:0] merged;
    logic [31:0] ext;

    always_comb begin
        pair   = p_split_q ? {rdata, hold_q} : {32'd0, rdata};
        merged = 32'(pair >> {p_o_q, 3'b000});
        case (p_sz_q)
            2'd0:    ext = {{24{p_sx_q & merged[7]}}, merged[7:0]};
            2'd1:    ext = {{16{p_sx_q & merged[15]}}, merged[15:0]};
            default: ext = merged;
        endcase
        vo = (p_ack_q && p_rd_q) ? ext : 32'd0;
    end

    assign ack  = p_ack_q;
    assign busy = (state_q == S_SPLIT);

endmodule

// File: tb/tb_spram_bhw.sv
// tb/tb_spram_bhw.sv - directed self-checking bench for spram_bhw
// Drives a 4-bank and a 1-bank instance with identical stimulus.
module tb_spram_bhw;
    logic        clk = 1'b0;
    logic        rst, req, we, sx;
    logic [1:0]  sz;
    logic [18:0] ai;
    logic [31:0] vi;
    logic [31:0] vo, vo1;
    logic        ack, ack1, busy, busy1;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    spram_bhw dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .sz(sz), .sx(sx),
        .ai(ai), .vi(vi), .vo(vo), .ack(ack), .busy(busy)
    );

    spram_bhw #(.BANKS(1)) dut1 (
        .clk(clk), .rst(rst), .req(req), .we(we), .sz(sz), .sx(sx),
        .ai(ai[16:0]), .vi(vi), .vo(vo1), .ack(ack1), .busy(busy1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic access(input logic w, input logic [1:0] s, input logic x,
                          input logic [18:0] a, input logic [31:0] d,
                          output int lat, output logic [31:0] r,
                          output logic [31:0] r1, output logic b);
        we = w; sz = s; sx = x; ai = a; vi = d; req = 1'b1;
        tick();
        req = 1'b0;
        b   = busy;
        lat = 1;
        while (ack !== 1'b1 && lat < 6) begin
            tick();
            lat++;
        end
        r  = vo;
        r1 = vo1;
    endtask

    task automatic wr(input string tag, input logic [18:0] a, input logic [31:0] d,
                      input logic [1:0] s, input int exp_lat);
        int lat;
        logic [31:0] r, r1;
        logic b;
        access(1'b1, s, 1'b0, a, d, lat, r, r1, b);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    endtask

    task automatic rd(input string tag, input logic [18:0] a, input logic [1:0] s,
                      input logic x, input logic [31:0] exp, input logic [31:0] exp1,
                      input int exp_lat);
        int lat;
        logic [31:0] r, r1;
        logic b;
        access(1'b0, s, x, a, 32'd0, lat, r, r1, b);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_vo"}, r, exp);
        chk({tag, "_vo1"}, r1, exp1);
    endtask

    initial begin
        int lat;
        logic [31:0] r, r1;
        logic b;

        rst = 1'b1; req = 1'b0; we = 1'b0; sz = 2'd0; sx = 1'b0; ai = '0; vi = '0;
        tick();
        tick();
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_vo", vo, 32'd0);
        chk("rst_ack1", 32'(ack1), 32'd0);
        rst = 1'b0;

        wr("init20", 19'h20, 32'h0, 2'd2, 1);
        wr("init24", 19'h24, 32'h0, 2'd2, 1);
        wr("init40", 19'h40, 32'h0, 2'd2, 1);
        wr("init44", 19'h44, 32'h11223344, 2'd2, 1);

        // aligned word and byte lanes
        wr("w10", 19'h10, 32'hDEADBEEF, 2'd2, 1);
        rd("r10", 19'h10, 2'd2, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 1);
        wr("b12", 19'h12, 32'h0000005A, 2'd0, 1);
        rd("r10b", 19'h10, 2'd2, 1'b0, 32'hDE5ABEEF, 32'hDE5ABEEF, 1);
        rd("b13sx", 19'h13, 2'd0, 1'b1, 32'hFFFFFFDE, 32'hFFFFFFDE, 1);
        rd("b13zx", 19'h13, 2'd0, 1'b0, 32'h000000DE, 32'h000000DE, 1);
        rd("h12sx", 19'h12, 2'd1, 1'b1, 32'hFFFFDE5A, 32'hFFFFDE5A, 1);
        tick();
        chk("idle_ack", 32'(ack), 32'd0);
        chk("idle_vo", vo, 32'd0);

        // split halfword
        access(1'b1, 2'd1, 1'b0, 19'h23, 32'h00001234, lat, r, r1, b);
        chk("wh23_lat", 32'(lat), 32'd2);
        chk("wh23_busy", 32'(b), 32'd1);
        rd("rh23", 19'h23, 2'd1, 1'b0, 32'h00001234, 32'h00001234, 2);
        rd("r20", 19'h20, 2'd2, 1'b0, 32'h34000000, 32'h34000000, 1);
        rd("r24", 19'h24, 2'd2, 1'b0, 32'h00000012, 32'h00000012, 1);
        rd("rw21", 19'h21, 2'd2, 1'b0, 32'h12340000, 32'h12340000, 2);

        // req held through a split read, then an aligned read
        we = 1'b0; sz = 2'd1; sx = 1'b0; ai = 19'h23; req = 1'b1;
        tick();
        chk("bsy_busy", 32'(busy), 32'd1);
        chk("bsy_ack0", 32'(ack), 32'd0);
        sz = 2'd2; ai = 19'h10;
        tick();
        chk("bsy_ack1", 32'(ack), 32'd1);
        chk("bsy_busy1", 32'(busy), 32'd0);
        chk("bsy_vo1", vo, 32'h00001234);
        tick();
        chk("bsy_ack2", 32'(ack), 32'd1);
        chk("bsy_vo2", vo, 32'hDE5ABEEF);
        req = 1'b0;
        tick();
        chk("bsy_ack3", 32'(ack), 32'd0);
        chk("bsy_vo3", vo, 32'd0);

        // back-to-back aligned reads
        req = 1'b1; sz = 2'd2; sx = 1'b0; ai = 19'h10;
        tick();
        chk("b2b_vo0", vo, 32'hDE5ABEEF);
        sz = 2'd0; sx = 1'b1; ai = 19'h13;
        tick();
        chk("b2b_ack1", 32'(ack), 32'd1);
        chk("b2b_vo1", vo, 32'hFFFFFFDE);
        sz = 2'd2; sx = 1'b0; ai = 19'h20;
        tick();
        chk("b2b_vo2", vo, 32'h34000000);
        req = 1'b0;
        tick();
        chk("b2b_ack3", 32'(ack), 32'd0);

        // wrap at the top of the 1-bank instance; bank crossing in the 4-bank one
        wr("i20000", 19'h20000, 32'h33333333, 2'd2, 1);
        wr("i00000", 19'h00000, 32'h22222222, 2'd2, 1);
        wr("i1fffc", 19'h1FFFC, 32'h11111111, 2'd2, 1);
        wr("w1fffe", 19'h1FFFE, 32'hA1B2C3D4, 2'd2, 2);
        rd("wrap_lo", 19'h1FFFC, 2'd2, 1'b0, 32'hC3D41111, 32'hC3D41111, 1);
        rd("wrap_0", 19'h00000, 2'd2, 1'b0, 32'h22222222, 32'h2222A1B2, 1);
        rd("wrap_b1", 19'h20000, 2'd2, 1'b0, 32'h3333A1B2, 32'h2222A1B2, 1);
        rd("wrap_rd", 19'h1FFFE, 2'd2, 1'b0, 32'hA1B2C3D4, 32'hA1B2C3D4, 2);

        // reset in the SPLIT cycle of a split write, with a request present under reset
        we = 1'b1; sz = 2'd2; sx = 1'b0; ai = 19'h41; vi = 32'hCAFEBABE; req = 1'b1;
        tick();
        chk("rms_busy", 32'(busy), 32'd1);
        rst = 1'b1; ai = 19'h44; vi = 32'hFFFFFFFF;
        tick();
        chk("rms_ack", 32'(ack), 32'd0);
        chk("rms_busy0", 32'(busy), 32'd0);
        chk("rms_busy1", 32'(busy1), 32'd0);
        rst = 1'b0; req = 1'b0;
        tick();
        chk("rms_ack2", 32'(ack), 32'd0);
        rd("rms40", 19'h40, 2'd2, 1'b0, 32'hFEBABE00, 32'hFEBABE00, 1);
        rd("rms44", 19'h44, 2'd2, 1'b0, 32'h11223344, 32'h11223344, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
